fp_mul_issue_stage: RTL and testbench

- Sequential front/back end wrapped around the combinational double-precision multiplier core `fp_mul`.
- Accepts tagged operand pairs over a valid/ready handshake and buffers them in an operand FIFO.
- Issues each pair to the `fp_mul` core, then carries the product through a LATENCY-deep register pipeline with whole-pipe backpressure.
- Delivers result, tag and IEEE exception flags over an output valid/ready handshake.

---
 rtl/fp_mul_issue_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_fp_mul_issue_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_issue_stage.sv
`default_nettype none
// fp_mul: combinational IEEE-754 binary64 multiplier with round-to-nearest-even and
// full subnormal support. Every NaN result is returned as the canonical quiet NaN.
module fp_mul (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  logic               sign;
  logic [10:0]        exp_a, exp_b, eff_a, eff_b;
  logic [51:0]        frac_a, frac_b;
  logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [52:0]        man_a, man_b;
  logic [105:0]       prod, norm;
  logic [6:0]         lz;
  logic signed [13:0] exp_n, sub_sh;
  logic [7:0]         rshift;
  logic [211:0]       wide;
  logic [52:0]        man_r;
  logic               guard, sticky, round_up;
  logic [53:0]        man_rnd;
  logic [11:0]        exp_base;
  logic [63:0]        packed_sum;

  function automatic logic [6:0] count_lz(input logic [105:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 106; i++)
      if (v[i]) n = 7'(105 - i);
    return n;
  endfunction

  assign sign   = a[63] ^ b[63];
  assign exp_a  = a[62:52];
  assign exp_b  = b[62:52];
  assign frac_a = a[51:0];
  assign frac_b = b[51:0];
  assign nan_a  = (exp_a == 11'h7FF) && (frac_a != 52'd0);
  assign nan_b  = (exp_b == 11'h7FF) && (frac_b != 52'd0);
  assign inf_a  = (exp_a == 11'h7FF) && (frac_a == 52'd0);
  assign inf_b  = (exp_b == 11'h7FF) && (frac_b == 52'd0);
  assign zero_a = (exp_a == 11'd0) && (frac_a == 52'd0);
  assign zero_b = (exp_b == 11'd0) && (frac_b == 52'd0);

  // Subnormals use exponent 1 with a zero hidden bit.
  assign eff_a = (exp_a == 11'd0) ? 11'd1 : exp_a;
  assign eff_b = (exp_b == 11'd0) ? 11'd1 : exp_b;
  assign man_a = {exp_a != 11'd0, frac_a};
  assign man_b = {exp_b != 11'd0, frac_b};
  assign prod  = {53'd0, man_a} * {53'd0, man_b};
  assign lz    = count_lz(prod);
  assign norm  = prod << lz;
  assign exp_n = $signed({3'b000, eff_a}) + $signed({3'b000, eff_b})
               - 14'sd1022 - $signed({7'd0, lz});

  // Results below the normal range are shifted right so the exponent field is 0;
  // a rounding carry into the hidden bit then naturally produces exponent 1.
  always_comb begin
    sub_sh = 14'sd1 - exp_n;
    if (exp_n > 14'sd0)
      rshift = 8'd0;
    else if (sub_sh > 14'sd127)
      rshift = 8'd127;
    else
      rshift = 8'(sub_sh);
    wide       = {norm, 106'd0} >> rshift;
    man_r      = wide[211:159];
    guard      = wide[158];
    sticky     = |wide[157:0];
    round_up   = guard & (sticky | man_r[0]);
    man_rnd    = {1'b0, man_r} + {53'd0, round_up};
    exp_base   = (exp_n > 14'sd0) ? 12'(exp_n - 14'sd1) : 12'd0;
    packed_sum = {exp_base, 52'd0} + {10'd0, man_rnd};
  end

  always_comb begin
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
      result = 64'h7FF8_0000_0000_0000;
    else if (inf_a || inf_b)
      result = {sign, 11'h7FF, 52'd0};
    else if (zero_a || zero_b)
      result = {sign, 63'd0};
    else if (packed_sum[63:52] >= 12'd2047)
      result = {sign, 11'h7FF, 52'd0};
    else
      result = {sign, packed_sum[62:0]};
  end
endmodule

// fp_mul_issue_stage: tagged operand FIFO feeding fp_mul, LATENCY-deep result pipeline
// with whole-pipe backpressure and IEEE exception flags. Rev 1.0
module fp_mul_issue_stage #(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2,
  parameter int TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [63:0]                   in_a,
  input  logic [63:0]                   in_b,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [63:0]                   out_result,
  output logic [TAG_W-1:0]              out_tag,
  output logic [2:0]                    out_flags,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [63:0]        fifo_a   [FIFO_DEPTH];
  logic [63:0]        fifo_b   [FIFO_DEPTH];
  logic [TAG_W-1:0]   fifo_tag [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               push, pop, adv, head_valid;
  logic [63:0]        head_a, head_b, core_result;
  logic [TAG_W-1:0]   head_tag;
  logic [2:0]         head_flags;

  logic [LATENCY-1:0] stg_valid;
  logic [63:0]        stg_result [LATENCY];
  logic [TAG_W-1:0]   stg_tag    [LATENCY];
  logic [2:0]         stg_flags  [LATENCY];

  logic fin_a, fin_b, zero_a, zero_b, inf_a, inf_b, snan_a, snan_b;

  assign in_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign head_valid = (count != '0);
  assign push       = in_valid && in_ready;
  assign adv        = !(out_valid && !out_ready);
  assign pop        = adv && head_valid;

  assign head_a   = fifo_a[rd_ptr];
  assign head_b   = fifo_b[rd_ptr];
  assign head_tag = fifo_tag[rd_ptr];

  fp_mul u_core (
    .a      (head_a),
    .b      (head_b),
    .result (core_result)
  );

  assign fin_a  = head_a[62:52] != 11'h7FF;
  assign fin_b  = head_b[62:52] != 11'h7FF;
  assign zero_a = head_a[62:0] == 63'd0;
  assign zero_b = head_b[62:0] == 63'd0;
  assign inf_a  = head_a[62:0] == {11'h7FF, 52'd0};
  assign inf_b  = head_b[62:0] == {11'h7FF, 52'd0};
  assign snan_a = !fin_a && (head_a[51:0] != 52'd0) && !head_a[51];
  assign snan_b = !fin_b && (head_b[51:0] != 52'd0) && !head_b[51];

  // {invalid, overflow, underflow}; quiet NaN propagation raises nothing.
  assign head_flags[2] = snan_a || snan_b || (inf_a && zero_b) || (zero_a && inf_b);
  assign head_flags[1] = fin_a && fin_b && (core_result[62:52] == 11'h7FF);
  assign head_flags[0] = fin_a && fin_b && !zero_a && !zero_b
                         && (core_result[62:52] == 11'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_a[i]   <= '0;
        fifo_b[i]   <= '0;
        fifo_tag[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_a[wr_ptr]   <= in_a;
        fifo_b[wr_ptr]   <= in_b;
        fifo_tag[wr_ptr] <= in_tag;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The whole pipe moves as one; bubbles travel with their valid bit cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_result[i] <= '0;
        stg_tag[i]    <= '0;
        stg_flags[i]  <= '0;
      end
    end else if (adv) begin
      stg_valid[0]  <= head_valid;
      stg_result[0] <= core_result;
      stg_tag[0]    <= head_tag;
      stg_flags[0]  <= head_flags;
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid[i]  <= stg_valid[i-1];
        stg_result[i] <= stg_result[i-1];
        stg_tag[i]    <= stg_tag[i-1];
        stg_flags[i]  <= stg_flags[i-1];
      end
    end
  end

  assign out_valid  = stg_valid[LATENCY-1];
  assign out_result = stg_result[LATENCY-1];
  assign out_tag    = stg_tag[LATENCY-1];
  assign out_flags  = stg_flags[LATENCY-1];
  assign occupancy  = count;
  assign busy       = head_valid || (|stg_valid);
endmodule
`default_nettype wire

// File: tb/tb_fp_mul_issue_stage.sv
`default_nettype none
// Bench for fp_mul_issue_stage: real-arithmetic reference model, in-order scoreboard,
// directed corner cases, backpressure, mid-flight reset and randomized traffic.
module tb_fp_mul_issue_stage;
  localparam int FIFO_DEPTH = 4;
  localparam int LATENCY    = 2;
  localparam int TAG_W      = 4;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [63:0]                 in_a = '0;
  logic [63:0]                 in_b = '0;
  logic [TAG_W-1:0]            in_tag = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic [63:0]                 out_result;
  logic [TAG_W-1:0]            out_tag;
  logic [2:0]                  out_flags;
  logic [$clog2(FIFO_DEPTH):0] occupancy;
  logic                        busy;

  fp_mul_issue_stage #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LATENCY    (LATENCY),
    .TAG_W      (TAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .occupancy  (occupancy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flags;
  } exp_t;

  exp_t mq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Host floating point supplies the IEEE product; NaN payloads collapse to the canonical qNaN.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] t);
    exp_t        e;
    real         ra, rb;
    logic [63:0] r;
    logic        fa, fb, za, zb, ia, ib, sa, sb;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    r  = $realtobits(ra * rb);
    if (r[62:52] == 11'h7FF && r[51:0] != 52'd0) r = 64'h7FF8_0000_0000_0000;
    fa = a[62:52] != 11'h7FF;
    fb = b[62:52] != 11'h7FF;
    za = a[62:0] == 63'd0;
    zb = b[62:0] == 63'd0;
    ia = !fa && a[51:0] == 52'd0;
    ib = !fb && b[51:0] == 52'd0;
    sa = !fa && a[51:0] != 52'd0 && !a[51];
    sb = !fb && b[51:0] != 52'd0 && !b[51];
    e.res      = r;
    e.tag      = t;
    e.flags[2] = sa || sb || (ia && zb) || (za && ib);
    e.flags[1] = fa && fb && r[62:52] == 11'h7FF;
    e.flags[0] = fa && fb && !za && !zb && r[62:52] == 11'd0;
    return e;
  endfunction

  function automatic logic [63:0] gen_op();
    logic [63:0] r64;
    logic [51:0] f;
    logic [10:0] e;
    logic        s;
    r64 = {$urandom(), $urandom()};
    f   = r64[51:0];
    if ($urandom_range(0, 3) == 0) f = 52'd0;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       begin e = 11'd0; f = 52'd0; end
      1:       e = 11'd0;
      2:       begin e = 11'h7FF; f = 52'd0; end
      3:       begin e = 11'h7FF; if (f == 52'd0) f = 52'd1; end
      4:       e = 11'($urandom_range(1, 60));
      5:       e = 11'($urandom_range(1990, 2046));
      default: e = 11'($urandom_range(960, 1090));
    endcase
    return {s, e, f};
  endfunction

  // Scoreboard: outputs checked mid-cycle, model updated for the handshakes of the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      chk("busy", busy, mq.size() != 0);
      chk("in_ready_vs_occupancy", in_ready, occupancy != FIFO_DEPTH);
      if (out_valid) begin
        if (mq.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          chk("result", out_result, mq[0].res);
          chk("tag", out_tag, mq[0].tag);
          chk("flags", out_flags, mq[0].flags);
          if (out_ready) void'(mq.pop_front());
        end
      end
      if (in_valid && in_ready) mq.push_back(model(in_a, in_b, in_tag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t,
                         input logic [63:0] want_res, input logic [2:0] want_flags);
    exp_t m;
    m = model(a, b, t);
    chk("model_result", m.res, want_res);
    chk("model_flags", m.flags, want_flags);
    chk("idle_in_ready", in_ready, 1'b1);
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      chk("early_out_valid", out_valid, 1'b0);
      tick();
    end
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_result", out_result, want_res);
    chk("lat_tag", out_tag, t);
    chk("lat_flags", out_flags, want_flags);
    tick();
  endtask

  initial begin
    int waited;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    run_one(64'h4000000000000000, 64'h4008000000000000, 4'd5, 64'h4018000000000000, 3'b000);
    run_one(64'h7FF0000000000000, 64'h0000000000000000, 4'd1, 64'h7FF8000000000000, 3'b100);
    run_one(64'h7FE0000000000000, 64'h4000000000000000, 4'd2, 64'h7FF0000000000000, 3'b010);
    run_one(64'h0010000000000000, 64'h0010000000000000, 4'd3, 64'h0000000000000000, 3'b001);
    run_one(64'h7FF0000000000001, 64'h3FF0000000000000, 4'd4, 64'h7FF8000000000000, 3'b100);
    run_one(64'h0008000000000000, 64'h4000000000000000, 4'd6, 64'h0010000000000000, 3'b000);

    // Backpressure: capacity is FIFO_DEPTH + LATENCY.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("bp_in_ready_open", in_ready, 1'b1);
      in_a = gen_op(); in_b = gen_op(); in_tag = 4'(i); in_valid = 1'b1;
      tick();
    end
    chk("bp_in_ready_full", in_ready, 1'b0);
    chk("bp_occupancy", occupancy, 4);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_head_tag", out_tag, 0);
    in_tag = 4'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_still_full", in_ready, 1'b0);
      chk("bp_occ_hold", occupancy, 4);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("bp_drain_valid", out_valid, 1'b1);
      chk("bp_drain_tag", out_tag, k);
      tick();
    end
    chk("bp_drained", out_valid, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      in_a = gen_op(); in_b = gen_op(); in_tag = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (busy && waited < 50) begin
      tick();
      waited++;
    end
    chk("random_drain_busy", busy, 1'b0);

    // Reset with operations queued and in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = gen_op(); in_b = gen_op(); in_tag = 4'(8 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_occupancy", occupancy, 0);
    chk("midrst_in_ready", in_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_no_stale", out_valid, 1'b0);
    end
    run_one(64'h4000000000000000, 64'h4008000000000000, 4'd9, 64'h4018000000000000, 3'b000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
